// File: rtl/huffman_pkg.sv
// Shared constants, table-entry record and FSM state encoding for the serial
// Huffman decoder.
package huffman_pkg;

   localparam int DEF_SYM_W   = 4;
   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;
   localparam int NSYM        = 1 << DEF_SYM_W;

   typedef struct packed {
      logic [DEF_LEN_W-1:0]   len;
      logic [DEF_MAX_LEN-1:0] code;
   } tbl_entry_t;

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_FAULT   = 2'd2;

endpackage

// File: rtl/huffman_bit_decoder_if.sv
// Bitstream, symbol stream and table-write signals of the Huffman decoder.
// The master side is the surrounding system; the slave side is the decoder.
interface huffman_bit_decoder_if
   import huffman_pkg::*;
#(
   parameter int SYM_W   = DEF_SYM_W,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W
);
   logic               TBL_WE;
   logic [SYM_W-1:0]   TBL_SYM;
   logic [LEN_W-1:0]   TBL_LEN;
   logic [MAX_LEN-1:0] TBL_CODE;
   logic               BIT_IN;
   logic               BIT_VALID;
   logic               BIT_READY;
   logic [SYM_W-1:0]   SYM_OUT;
   logic               SYM_VALID;
   logic               SYM_READY;
   logic               ERR;

   modport master (
      output TBL_WE, TBL_SYM, TBL_LEN, TBL_CODE, BIT_IN, BIT_VALID, SYM_READY,
      input  BIT_READY, SYM_OUT, SYM_VALID, ERR
   );

   modport slave (
      input  TBL_WE, TBL_SYM, TBL_LEN, TBL_CODE, BIT_IN, BIT_VALID, SYM_READY,
      output BIT_READY, SYM_OUT, SYM_VALID, ERR
   );
endinterface

// File: rtl/huffman_bit_decoder_match.sv
// Combinational code matcher: compares the candidate code against every table
// entry and returns the lowest matching index.
module huffman_match
   import huffman_pkg::*;
#(
   parameter int SYM_W   = DEF_SYM_W,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W,
   localparam int NENT   = 1 << SYM_W
) (
   input  logic [MAX_LEN-1:0] cand,
   input  logic [LEN_W-1:0]   cand_len,
   input  logic [LEN_W-1:0]   tbl_len  [NENT],
   input  logic [MAX_LEN-1:0] tbl_code [NENT],
   output logic               hit,
   output logic [SYM_W-1:0]   sym
);

   logic [MAX_LEN-1:0] mask;
   logic [NENT-1:0]    match;

   always_comb begin
      mask = '0;
      for (int b = 0; b < MAX_LEN; b++)
         mask[b] = (LEN_W'(b) < cand_len);
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < NENT; i++)
         match[i] = (tbl_len[i] == cand_len) && (((tbl_code[i] ^ cand) & mask) == '0);
   end

   // Scan from the top so the lowest index is written last and wins ties.
   always_comb begin
      hit = 1'b0;
      sym = '0;
      for (int i = NENT - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit = 1'b1;
            sym = SYM_W'(i);
         end
      end
   end

endmodule

// File: rtl/huffman_bit_decoder.sv
// Serial Huffman decoder: one code bit per cycle in, one symbol out per
// matched code, with a runtime-loadable code table.
//
// state   | meaning
// COLLECT | accepting bits into the accumulator
// HOLD    | symbol presented, waiting for SYM_READY
// FAULT   | MAX_LEN bits without a match; left only by RST
module huffman_bit_decoder
   import huffman_pkg::*;
#(
   parameter int SYM_W   = DEF_SYM_W,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W
) (
   input logic                  CLK,
   input logic                  RST,
   huffman_bit_decoder_if.slave bus
);

   localparam int NENT = 1 << SYM_W;

   logic [LEN_W-1:0]   tbl_len  [NENT];
   logic [MAX_LEN-1:0] tbl_code [NENT];

   logic [1:0]         state;
   logic [MAX_LEN-1:0] acc;
   logic [LEN_W-1:0]   acc_len;
   logic [MAX_LEN-1:0] cand;
   logic [LEN_W-1:0]   cand_len;
   logic [LEN_W-1:0]   wr_len;
   logic [SYM_W-1:0]   sym_out;
   logic [SYM_W-1:0]   hit_sym;
   logic               sym_valid;
   logic               err;
   logic               hit;

   assign cand     = {acc[MAX_LEN-2:0], bus.BIT_IN};
   assign cand_len = acc_len + 1'b1;
   // Over-long lengths are stored as unused entries.
   assign wr_len   = (bus.TBL_LEN > LEN_W'(MAX_LEN)) ? '0 : bus.TBL_LEN;

   huffman_match #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_match (
      .cand     (cand),
      .cand_len (cand_len),
      .tbl_len  (tbl_len),
      .tbl_code (tbl_code),
      .hit      (hit),
      .sym      (hit_sym)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NENT; i++) begin
            tbl_len[i]  <= '0;
            tbl_code[i] <= '0;
         end
         state     <= ST_COLLECT;
         acc       <= '0;
         acc_len   <= '0;
         sym_out   <= '0;
         sym_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (bus.TBL_WE) begin
            tbl_len[bus.TBL_SYM]  <= wr_len;
            tbl_code[bus.TBL_SYM] <= bus.TBL_CODE;
         end
         case (state)
            ST_COLLECT: begin
               // A table write flushes the partial code and drops this cycle's bit.
               if (bus.TBL_WE) begin
                  acc     <= '0;
                  acc_len <= '0;
               end else if (bus.BIT_VALID) begin
                  if (hit) begin
                     sym_out   <= hit_sym;
                     sym_valid <= 1'b1;
                     acc       <= '0;
                     acc_len   <= '0;
                     state     <= ST_HOLD;
                  end else if (cand_len == LEN_W'(MAX_LEN)) begin
                     err   <= 1'b1;
                     state <= ST_FAULT;
                  end else begin
                     acc     <= cand;
                     acc_len <= cand_len;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.SYM_READY) begin
                  sym_valid <= 1'b0;
                  state     <= ST_COLLECT;
               end
            end
            ST_FAULT: ;
            default: begin
               err   <= 1'b1;
               state <= ST_FAULT;
            end
         endcase
      end
   end

   assign bus.BIT_READY = (state == ST_COLLECT);
   assign bus.SYM_OUT   = sym_out;
   assign bus.SYM_VALID = sym_valid;
   assign bus.ERR       = err;

endmodule

// File: tb/tb_huffman_bit_decoder.sv
// Directed scenarios plus randomized traffic for huffman_bit_decoder, checked
// cycle by cycle against a bit-string reference model.
module tb_huffman_bit_decoder;
   import huffman_pkg::*;

   logic CLK;
   logic RST;

   huffman_bit_decoder_if bus ();

   huffman_bit_decoder dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: table, bits received since the last symbol, output view.
   tbl_entry_t m_tbl [NSYM];
   int         m_bits[$];
   bit         m_pend;
   bit         m_err;
   int         m_sym;
   bit         m_took;
   bit         sr_now;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clk1();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSYM; i++) begin
         m_tbl[i].len  = '0;
         m_tbl[i].code = '0;
      end
      m_bits.delete();
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_sym  = 0;
   endtask

   // Lowest entry whose length equals the bit count and whose low bits equal
   // the received string read MSB-first; -1 if none.
   function automatic int model_lookup();
      int n = m_bits.size();
      int v = 0;
      for (int k = 0; k < n; k++) v = v * 2 + m_bits[k];
      for (int i = 0; i < NSYM; i++)
         if (int'(m_tbl[i].len) == n && (int'(m_tbl[i].code) % (1 << n)) == v)
            return i;
      return -1;
   endfunction

   task automatic cycle(input bit rst, input bit we, input int wsym, input int wlen,
                        input int wcode, input bit bv, input bit bi, input bit sr);
      bit ready;
      int idx;
      RST           = rst;
      bus.TBL_WE    = we;
      bus.TBL_SYM   = 4'(wsym);
      bus.TBL_LEN   = 4'(wlen);
      bus.TBL_CODE  = 8'(wcode);
      bus.BIT_VALID = bv;
      bus.BIT_IN    = bi;
      bus.SYM_READY = sr;
      ready = !m_pend && !m_err;
      chk("bit_ready", 32'(bus.BIT_READY), 32'(ready));
      clk1();
      m_took = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         if (ready) begin
            if (we) m_bits.delete();
            else if (bv) begin
               m_took = 1'b1;
               m_bits.push_back(int'(bi));
               idx = model_lookup();
               if (idx >= 0) begin
                  m_sym  = idx;
                  m_pend = 1'b1;
                  m_bits.delete();
               end else if (m_bits.size() == DEF_MAX_LEN) begin
                  m_err = 1'b1;
               end
            end
         end else if (m_pend && sr) begin
            m_pend = 1'b0;
         end
         if (we) begin
            m_tbl[wsym].len  = (wlen > DEF_MAX_LEN) ? '0 : 4'(wlen);
            m_tbl[wsym].code = 8'(wcode);
         end
      end
      chk("sym_valid", 32'(bus.SYM_VALID), 32'(m_pend));
      chk("err", 32'(bus.ERR), 32'(m_err));
      chk("sym_out", 32'(bus.SYM_OUT), 32'(m_sym));
      RST           = 1'b0;
      bus.TBL_WE    = 1'b0;
      bus.BIT_VALID = 1'b0;
      bus.SYM_READY = 1'b0;
   endtask

   task automatic idle(input bit sr);
      cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, sr);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input int s, input int len, input int code);
      cycle(1'b0, 1'b1, s, len, code, 1'b0, 1'b0, sr_now);
   endtask

   // Present a bit until the decoder takes it; bounded so a stuck decoder fails.
   task automatic send(input bit b);
      int tries = 0;
      do begin
         cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, b, sr_now);
         tries++;
      end while (!m_took && !m_err && tries < 20);
      if (!m_took && !m_err) chk("send_timeout", 32'(tries), 32'(0));
   endtask

   task automatic load_s1();
      load(0, 1, 'b0);
      load(1, 2, 'b10);
      load(2, 3, 'b110);
      load(3, 3, 'b111);
   endtask

   initial begin
      int bits9 [9] = '{0, 1, 0, 1, 1, 0, 1, 1, 1};

      RST = 1'b1;
      bus.TBL_WE = 1'b0; bus.TBL_SYM = '0; bus.TBL_LEN = '0; bus.TBL_CODE = '0;
      bus.BIT_IN = 1'b0; bus.BIT_VALID = 1'b0; bus.SYM_READY = 1'b0;
      model_reset();
      sr_now = 1'b0;
      clk1();
      clk1();
      RST = 1'b0;
      chk("reset_bit_ready", 32'(bus.BIT_READY), 32'(1));
      chk("reset_sym_valid", 32'(bus.SYM_VALID), 32'(0));
      chk("reset_err", 32'(bus.ERR), 32'(0));
      chk("reset_sym_out", 32'(bus.SYM_OUT), 32'(0));

      // Basic prefix code, sink always ready.
      load_s1();
      sr_now = 1'b1;
      foreach (bits9[k]) send(bits9[k][0]);
      idle(1'b1);

      // Back-pressure on a held symbol.
      sr_now = 1'b0;
      send(1'b1); send(1'b1); send(1'b0);
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
      sr_now = 1'b1;
      send(1'b0);
      idle(1'b1);

      // Full-length code, then an unmatched run into FAULT.
      do_reset();
      load(15, 8, 'hFF);
      for (int k = 0; k < 8; k++) send(1'b1);
      idle(1'b1);
      for (int k = 0; k < 8; k++) send(1'b0);
      chk("fault_err", 32'(bus.ERR), 32'(1));
      load(2, 1, 'b0);
      cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
      do_reset();
      chk("fault_cleared", 32'(bus.ERR), 32'(0));

      // Table write flushes a partial code and drops the presented bit.
      load_s1();
      send(1'b1); send(1'b1);
      cycle(1'b0, 1'b1, 3, 3, 'b111, 1'b1, 1'b1, 1'b1);
      send(1'b0);
      chk("flush_sym", 32'(bus.SYM_OUT), 32'(0));
      idle(1'b1);

      // Reset mid-code empties the table.
      send(1'b1); send(1'b1);
      do_reset();
      send(1'b0);
      load_s1();
      send(1'b0);
      idle(1'b1);

      // Overlapping codes: shortest match, then lowest index.
      do_reset();
      load(5, 1, 'b1);
      load(6, 2, 'b10);
      load(7, 2, 'b01);
      load(8, 2, 'b01);
      load(9, 12, 'b0);
      send(1'b1);
      idle(1'b1);
      send(1'b0); send(1'b1);
      idle(1'b1);

      // Random tables and traffic.
      do_reset();
      for (int i = 0; i < NSYM; i++)
         load(i, $urandom_range(0, 9), $urandom_range(0, 255));
      for (int c = 0; c < 1500; c++) begin
         if (m_err || $urandom_range(0, 199) == 0) begin
            do_reset();
            for (int i = 0; i < NSYM; i++)
               load(i, $urandom_range(1, 5), $urandom_range(0, 255));
         end else begin
            cycle(1'b0, ($urandom_range(0, 29) == 0), $urandom_range(0, 15),
                  $urandom_range(0, 9), $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/huffman_bit_decoder.md
Name: huffman_bit_decoder

Overview:
Serial Huffman decoder, the receive-side counterpart of the team's Huffman encoder path. Consumes a code bitstream one bit per cycle and emits 4-bit symbols. The code table is loaded at runtime through a write port. It sits between the bitstream source (bit valid/ready) and the symbol sink (symbol valid/ready).

Parameters:
SYM_W, 4, symbol width in bits; the table holds NSYM = 2**SYM_W entries.
MAX_LEN, 8, maximum code length in bits.
LEN_W, 4, width of the code-length fields; must hold the value MAX_LEN.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RST  in  1  synchronous reset, active high.
TBL_WE  in  1  table write strobe.
TBL_SYM  in  SYM_W  table index (symbol) being written.
TBL_LEN  in  LEN_W  code length; 0 = entry unused; values above MAX_LEN are treated as 0.
TBL_CODE  in  MAX_LEN  code, right-aligned; the first transmitted bit is TBL_CODE[TBL_LEN-1].
BIT_IN  in  1  next code bit.
BIT_VALID  in  1  BIT_IN is valid.
BIT_READY  out  1  decoder accepts a bit this cycle.
SYM_OUT  out  SYM_W  decoded symbol.
SYM_VALID  out  1  SYM_OUT is valid.
SYM_READY  in  1  sink accepts SYM_OUT.
ERR  out  1  sticky error: MAX_LEN bits arrived with no match.

Behaviour:
- One clock CLK. Reset is synchronous and active-high on RST. RST overrides every other input in the same cycle.
- Reset values:
  - All table lengths = 0; acc = 0; acc_len = 0.
  - SYM_OUT = 0, SYM_VALID = 0, ERR = 0, state = COLLECT.
  - BIT_READY is 1 in the first cycle after reset.
- States:
  - COLLECT: BIT_READY = 1.
  - HOLD: SYM_VALID = 1, BIT_READY = 0.
  - FAULT: ERR = 1, BIT_READY = 0, SYM_VALID = 0.
- BIT_READY is combinational from state only, so there is no combinational path from inputs to BIT_READY.
- Bit accept (COLLECT, BIT_VALID = 1):
  - Candidate: cand = {acc[MAX_LEN-2:0], BIT_IN} and cand_len = acc_len + 1.
  - Entry i matches when len[i] == cand_len and code[i][cand_len-1:0] == cand[cand_len-1:0].
  - On a match: SYM_OUT <= lowest matching index, SYM_VALID <= 1, acc/acc_len <= 0, go to HOLD. SYM_VALID rises the cycle after the final bit is accepted.
  - No match and cand_len == MAX_LEN: ERR <= 1, go to FAULT.
  - Otherwise: acc <= cand, acc_len <= cand_len, stay in COLLECT.
- HOLD:
  - SYM_OUT and SYM_VALID stay stable until SYM_READY = 1.
  - On the handshake cycle: SYM_VALID <= 0, go to COLLECT. The next bit is accepted one cycle later.
- Throughput: a code of length L plus an immediate SYM_READY costs L+1 cycles per symbol.
- FAULT is left only by RST. TBL_WE is still honoured in FAULT but does not clear ERR.
- Table write (TBL_WE = 1):
  - Entry TBL_SYM <= {TBL_LEN, TBL_CODE} at the clock edge.
  - In COLLECT, acc/acc_len are flushed to 0 and any bit presented that cycle is dropped; BIT_READY still reads 1 that cycle.
  - In HOLD, the pending symbol is kept and acc is already 0.
  - Writing an entry whose code is currently being matched takes effect from the next cycle.
- Tables that are not prefix-free are allowed: the shortest match wins at the first bit it completes, and ties go to the lowest index.
- An empty table (all lengths 0) yields ERR after MAX_LEN bits.
- RST mid-code or mid-HOLD discards the partial code, the pending symbol and the whole table.

Decomposition:
- Shared package huffman_pkg holds:
  - SYM_W, MAX_LEN, LEN_W defaults.
  - Table-entry record {len, code}.
  - State encoding: COLLECT, HOLD, FAULT.
  - The constant NSYM.
- One natural sub-module: huffman_match. It is combinational: cand, cand_len and the table in; hit plus the lowest matching index out. It is NSYM comparators plus a priority encoder.
- The table register file, accumulator and FSM stay in the top.

Test Plan:
1. Load 0:'0'(len 1), 1:'10', 2:'110', 3:'111'. Stream 0,1,0,1,1,0,1,1,1 with SYM_READY = 1 -> SYM_OUT 0,1,2,3. Each SYM_VALID pulses one cycle after the last bit of its code.
2. Same table, stream '110' with SYM_READY held 0 for 3 cycles -> SYM_OUT = 2 stays stable, BIT_READY = 0 throughout, the next bit is accepted one cycle after the handshake, and no bits are lost.
3. Load only 15:8'hFF (len 8). Stream eight 1s -> SYM_OUT = 15 on the 8th bit, ERR = 0. Then stream eight 0s -> ERR = 1 after the 8th bit and BIT_READY = 0. TBL_WE does not clear ERR; RST does.
4. Table from scenario 1. Stream '1','1', then pulse TBL_WE (re-write entry 3 as '111'), then stream '0' -> the partial code is flushed and SYM_OUT = 0 is emitted, not 2.
5. Table from scenario 1. Stream '1','1', assert RST, then stream '0' -> no SYM_VALID (the table is empty after reset). After reloading, '0' -> SYM_OUT = 0.
6. Overlapping codes: 5:'1' and 6:'10' -> stream '1' yields SYM_OUT = 5 after 1 bit (shortest match wins). Entries 7 and 8 both '01' -> stream '01' yields SYM_OUT = 7.
